// File: rtl/sdram_access_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_access_scheduler: arbitrates store/load/refresh onto the burst engine
// Rev 1.0
// ---------------------------------------------------------------------------
module sdram_access_scheduler #(
  parameter int REFRESH_INTERVAL = 110,
  parameter int REFRESH_MAX      = 8,
  parameter int REFRESH_URGENT   = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_req,
  output logic       s_ack,
  input  logic       s_cache_row,
  input  logic [9:0] s_sdram_row,
  input  logic       l_req,
  output logic       l_ack,
  input  logic       l_cache_row,
  input  logic [9:0] l_sdram_row,
  output logic       cmd_start,
  output logic [1:0] cmd_op,
  output logic       cmd_cache_row,
  output logic [9:0] cmd_sdram_row,
  input  logic       cmd_done,
  output logic       busy,
  output logic       refresh_overrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] OP_IDLE    = 2'd0;
  localparam logic [1:0] OP_STORE   = 2'd1;
  localparam logic [1:0] OP_LOAD    = 2'd2;
  localparam logic [1:0] OP_REFRESH = 2'd3;

  localparam logic [9:0] TIMER_LAST  = 10'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] DEBT_MAX    = 4'(REFRESH_MAX);
  localparam logic [3:0] DEBT_URGENT = 4'(REFRESH_URGENT);

  state_t     state_q, state_d;
  logic [9:0] timer_q, timer_d;
  logic [3:0] debt_q, debt_d;
  logic       overrun_q, overrun_d;
  logic       s_ack_q, s_ack_d;
  logic       l_ack_q, l_ack_d;
  logic       start_q, start_d;
  logic [1:0] op_q, op_d;
  logic       cache_q, cache_d;
  logic [9:0] row_q, row_d;

  logic w_credit;
  logic w_refresh_done;
  logic w_s_pend;
  logic w_l_pend;

  assign w_credit       = (timer_q == TIMER_LAST);
  assign w_refresh_done = (state_q == ST_BUSY) && cmd_done && (op_q == OP_REFRESH);
  assign w_s_pend       = (s_req != s_ack_q);
  assign w_l_pend       = (l_req != l_ack_q);

  // Refresh bookkeeping: a credit and a completed refresh in one cycle cancel out.
  always_comb begin
    timer_d   = w_credit ? 10'd0 : timer_q + 10'd1;
    debt_d    = debt_q;
    overrun_d = overrun_q | (w_credit && (debt_q == DEBT_MAX));
    if (w_credit && !w_refresh_done) begin
      if (debt_q != DEBT_MAX) debt_d = debt_q + 4'd1;
    end else if (w_refresh_done && !w_credit) begin
      if (debt_q != 4'd0) debt_d = debt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    op_d    = op_q;
    cache_d = cache_q;
    row_d   = row_q;
    s_ack_d = s_ack_q;
    l_ack_d = l_ack_q;
    case (state_q)
      ST_IDLE: begin
        if (debt_q >= DEBT_URGENT) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          op_d    = OP_REFRESH;
          cache_d = 1'b0;
          row_d   = 10'd0;
        end else if (w_l_pend) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          op_d    = OP_LOAD;
          cache_d = l_cache_row;
          row_d   = l_sdram_row;
        end else if (w_s_pend) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          op_d    = OP_STORE;
          cache_d = s_cache_row;
          row_d   = s_sdram_row;
        end else if (debt_q != 4'd0) begin
          state_d = ST_BUSY;
          start_d = 1'b1;
          op_d    = OP_REFRESH;
          cache_d = 1'b0;
          row_d   = 10'd0;
        end
      end
      ST_BUSY: begin
        if (cmd_done) begin
          state_d = ST_IDLE;
          op_d    = OP_IDLE;
          cache_d = 1'b0;
          row_d   = 10'd0;
          if (op_q == OP_STORE) s_ack_d = ~s_ack_q;
          if (op_q == OP_LOAD)  l_ack_d = ~l_ack_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= 10'd0;
      debt_q    <= 4'd0;
      overrun_q <= 1'b0;
      s_ack_q   <= 1'b0;
      l_ack_q   <= 1'b0;
      start_q   <= 1'b0;
      op_q      <= OP_IDLE;
      cache_q   <= 1'b0;
      row_q     <= 10'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      debt_q    <= debt_d;
      overrun_q <= overrun_d;
      s_ack_q   <= s_ack_d;
      l_ack_q   <= l_ack_d;
      start_q   <= start_d;
      op_q      <= op_d;
      cache_q   <= cache_d;
      row_q     <= row_d;
    end
  end

  assign s_ack           = s_ack_q;
  assign l_ack           = l_ack_q;
  assign cmd_start       = start_q;
  assign cmd_op          = op_q;
  assign cmd_cache_row   = cache_q;
  assign cmd_sdram_row   = row_q;
  assign busy            = (state_q == ST_BUSY);
  assign refresh_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_access_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_access_scheduler: randomized scoreboard bench for the scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sdram_access_scheduler;

  localparam int INTERVAL = 110;
  localparam int DMAX     = 8;
  localparam int DURG     = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_req, s_ack, s_cache_row;
  logic [9:0] s_sdram_row;
  logic       l_req, l_ack, l_cache_row;
  logic [9:0] l_sdram_row;
  logic       cmd_start;
  logic [1:0] cmd_op;
  logic       cmd_cache_row;
  logic [9:0] cmd_sdram_row;
  logic       cmd_done;
  logic       busy;
  logic       refresh_overrun;

  always #5 clk = ~clk;

  sdram_access_scheduler #(
    .REFRESH_INTERVAL(INTERVAL),
    .REFRESH_MAX     (DMAX),
    .REFRESH_URGENT  (DURG)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .s_req          (s_req),
    .s_ack          (s_ack),
    .s_cache_row    (s_cache_row),
    .s_sdram_row    (s_sdram_row),
    .l_req          (l_req),
    .l_ack          (l_ack),
    .l_cache_row    (l_cache_row),
    .l_sdram_row    (l_sdram_row),
    .cmd_start      (cmd_start),
    .cmd_op         (cmd_op),
    .cmd_cache_row  (cmd_cache_row),
    .cmd_sdram_row  (cmd_sdram_row),
    .cmd_done       (cmd_done),
    .busy           (busy),
    .refresh_overrun(refresh_overrun)
  );

  typedef struct packed {
    logic [1:0] op;
    logic       cache;
    logic [9:0] row;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_got, mon_exp;
  int   errors = 0;
  int   checks = 0;

  // Reference model: requests, debt and acks tracked as plain counters/flags.
  int m_cyc, m_debt, m_out, eng_cnt;
  bit m_overrun, m_sack, m_lack;
  bit stall;
  int mode;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_cyc = 0; m_debt = 0; m_out = 0; eng_cnt = 0;
    m_overrun = 1'b0; m_sack = 1'b0; m_lack = 1'b0;
    exp_q.delete();
  endfunction

  always @(negedge clk) begin
    if (reset_n && cmd_start) begin
      mon_got = {cmd_op, cmd_cache_row, cmd_sdram_row};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd at %0t: got 0x%0h expected none", $time, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cmd_fields", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  // One cycle: check state from the previous edge, drive inputs, predict the next edge.
  task automatic step();
    bit   credit, done, rdone, grant;
    cmd_t g;
    check("state", 32'({busy, s_ack, l_ack, refresh_overrun, cmd_op}),
          32'({(m_out != 0), m_sack, m_lack, m_overrun, 2'(m_out)}));

    if (s_req == m_sack) begin
      s_cache_row = 1'($urandom);
      s_sdram_row = 10'($urandom);
      if (mode != 0 && $urandom_range(7) == 0) s_req = ~s_req;
    end
    if (l_req == m_lack) begin
      l_cache_row = 1'($urandom);
      l_sdram_row = 10'($urandom);
      if (mode != 0 && $urandom_range(9) == 0) l_req = ~l_req;
    end

    cmd_done = 1'b0;
    if (m_out != 0) begin
      if (!stall) begin
        if (eng_cnt == 0) cmd_done = 1'b1;
        else eng_cnt--;
      end
    end else if (!stall && $urandom_range(15) == 0) begin
      cmd_done = 1'b1;
    end

    credit = ((m_cyc % INTERVAL) == INTERVAL - 1);
    done   = (m_out != 0) && cmd_done;
    rdone  = done && (m_out == 3);
    grant  = 1'b0;
    g      = '0;
    if (m_out == 0) begin
      grant = 1'b1;
      if (m_debt >= DURG)    g = {2'd3, 1'b0, 10'd0};
      else if (l_req != m_lack) g = {2'd2, l_cache_row, l_sdram_row};
      else if (s_req != m_sack) g = {2'd1, s_cache_row, s_sdram_row};
      else if (m_debt > 0)   g = {2'd3, 1'b0, 10'd0};
      else grant = 1'b0;
    end
    if (credit && m_debt == DMAX) m_overrun = 1'b1;
    if (credit && !rdone && m_debt < DMAX) m_debt++;
    if (rdone && !credit && m_debt > 0) m_debt--;
    if (done) begin
      if (m_out == 1) m_sack = ~m_sack;
      if (m_out == 2) m_lack = ~m_lack;
      m_out = 0;
    end else if (grant) begin
      m_out = int'(g.op);
      exp_q.push_back(g);
      eng_cnt = $urandom_range(0, 20);
    end
    m_cyc++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset_n = 1'b0;
    s_req = 1'b0; s_cache_row = 1'b0; s_sdram_row = '0;
    l_req = 1'b0; l_cache_row = 1'b0; l_sdram_row = '0;
    cmd_done = 1'b0; stall = 1'b0; mode = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({s_ack, l_ack, cmd_start, cmd_op, cmd_cache_row,
                                 cmd_sdram_row, busy, refresh_overrun}), 32'd0);
    reset_n = 1'b1;

    mode = 0; run(3 * INTERVAL + 50);
    mode = 1; run(2000);
    stall = 1'b1; run(11 * INTERVAL);
    stall = 1'b0; run(1500);

    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      if (m_out == 1) got = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL store_grant_wait: got none expected a store grant");
    end
    stall = 1'b1;
    step();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_mid_store", 32'({s_ack, l_ack, cmd_start, cmd_op, cmd_cache_row,
                                   cmd_sdram_row, busy, refresh_overrun}), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_held", 32'({s_ack, l_ack, cmd_start, cmd_op, busy, refresh_overrun}), 32'd0);
    stall = 1'b0;
    reset_n = 1'b1;
    run(1500);

    check("queue_empty", 32'(exp_q.size() > 1), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
